press_counter_bank: RTL and testbench

Parametrised multi-channel successor to the single-channel press counter. Each channel takes an up and a down push-button, synchronises and debounces both, and converts each debounced press into one increment or decrement of a per-channel counter. Overflow handling is configurable as wrap or saturate. The block sits between the board buttons and the display/VGA logic, which read either the selected channel or the full counter vector.

---
 rtl/press_pkg.sv | 30 +++
 rtl/press_debouncer.sv | 47 ++++
 rtl/press_counter_bank.sv | 122 ++++++++++++
 tb/tb_press_counter_bank.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/press_pkg.sv
// Shared constants and helpers for the press counter bank and its debouncers.
package press_pkg;

   localparam int PRESS_WRAP = 0;
   localparam int PRESS_SAT  = 1;

   localparam int CHANNELS_MIN  = 1;
   localparam int CHANNELS_MAX  = 16;
   localparam int WIDTH_MIN     = 2;
   localparam int WIDTH_MAX     = 16;
   localparam int DEBOUNCE_MIN  = 1;
   localparam int DEBOUNCE_MAX  = 1 << 20;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Vectors still need one bit when only a single value is possible.
   function automatic int clog2_min1(input int value);
      return (clog2(value) < 1) ? 1 : clog2(value);
   endfunction

endpackage

// File: rtl/press_debouncer.sv
// One button: 2-FF synchroniser, stability-counter debouncer and rising-edge press pulse.
module press_debouncer
   import press_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam int            CW   = clog2_min1(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_q;
   logic [CW-1:0] stable_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         level      <= 1'b0;
         level_q    <= 1'b0;
         stable_cnt <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_q <= level;
         // Any sample agreeing with the accepted level restarts the stability window.
         if (sync2 == level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == LAST) begin
            level      <= sync2;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + CW'(1);
         end
      end
   end

   assign press = level & ~level_q;

endmodule

// File: rtl/press_counter_bank.sv
// Multi-channel up/down press counter with debounced buttons, wrap or saturate limits,
// sticky overflow flags, a registered channel-select readout and a flat counter vector.
module press_counter_bank
   import press_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SATURATE        = 0,
   parameter int RESET_VALUE     = 0
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [CHANNELS-1:0]           countu,
   input  logic [CHANNELS-1:0]           countd,
   input  logic                          clear,
   input  logic [clog2_min1(CHANNELS)-1:0] sel,
   output logic [WIDTH-1:0]              nr_presses,
   output logic [CHANNELS*WIDTH-1:0]     count_all,
   output logic [CHANNELS-1:0]           press_evt,
   output logic [CHANNELS-1:0]           ovf_flag
);

   localparam int               SELW     = clog2_min1(CHANNELS);
   localparam int               SLOTS    = 1 << SELW;
   localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] MAX_VAL  = '1;
   localparam logic [WIDTH-1:0] MIN_VAL  = '0;
   localparam bit               SAT_MODE = (SATURATE == PRESS_SAT);

   if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
       WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
       DEBOUNCE_CYCLES < DEBOUNCE_MIN || DEBOUNCE_CYCLES > DEBOUNCE_MAX ||
       (SATURATE != PRESS_WRAP && SATURATE != PRESS_SAT)) begin : g_bad_param
      $error("press_counter_bank: parameter out of range");
   end

   logic [CHANNELS-1:0] up_press;
   logic [CHANNELS-1:0] dn_press;
   logic [WIDTH-1:0]    cnt  [CHANNELS];
   logic [WIDTH-1:0]    slot [SLOTS];

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
      press_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_up (
         .clock (clock),
         .reset (reset),
         .raw   (countu[ch]),
         .press (up_press[ch])
      );

      press_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_dn (
         .clock (clock),
         .reset (reset),
         .raw   (countd[ch]),
         .press (dn_press[ch])
      );

      assign count_all[ch*WIDTH +: WIDTH] = cnt[ch];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt[ch] <= RST_VAL;
         end
         press_evt <= '0;
         ovf_flag  <= '0;
      end else if (clear) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt[ch] <= RST_VAL;
         end
         press_evt <= '0;
         ovf_flag  <= '0;
      end else begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            // Opposing presses in the same cycle cancel and produce no event.
            press_evt[ch] <= up_press[ch] ^ dn_press[ch];
            if (up_press[ch] && !dn_press[ch]) begin
               if (cnt[ch] == MAX_VAL) begin
                  ovf_flag[ch] <= 1'b1;
                  if (!SAT_MODE) begin
                     cnt[ch] <= MIN_VAL;
                  end
               end else begin
                  cnt[ch] <= cnt[ch] + WIDTH'(1);
               end
            end else if (dn_press[ch] && !up_press[ch]) begin
               if (cnt[ch] == MIN_VAL) begin
                  ovf_flag[ch] <= 1'b1;
                  if (!SAT_MODE) begin
                     cnt[ch] <= MAX_VAL;
                  end
               end else begin
                  cnt[ch] <= cnt[ch] - WIDTH'(1);
               end
            end
         end
      end
   end

   // Select slots beyond the last channel read as zero.
   for (genvar s = 0; s < SLOTS; s++) begin : g_slot
      if (s < CHANNELS) begin : g_used
         assign slot[s] = cnt[s];
      end else begin : g_empty
         assign slot[s] = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         nr_presses <= RST_VAL;
      end else begin
         nr_presses <= slot[sel];
      end
   end

endmodule

// File: tb/tb_press_counter_bank.sv
// Directed self-checking bench: wrap and saturate banks plus a 3-channel bank with non-zero reset value.
module tb_press_counter_bank;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  countu;
   logic [3:0]  countd;
   logic        clear;
   logic [1:0]  sel;

   logic [7:0]  nr_w;
   logic [31:0] all_w;
   logic [3:0]  press_w;
   logic [3:0]  ovf_w;
   logic [7:0]  nr_s;
   logic [31:0] all_s;
   logic [3:0]  press_s;
   logic [3:0]  ovf_s;
   logic [3:0]  nr_r;
   logic [11:0] all_r;
   logic [2:0]  press_r;
   logic [2:0]  ovf_r;

   int checks = 0;
   int fails  = 0;
   int evt_cnt_w [4];
   int evt_cnt_s [4];

   always #5 clock = ~clock;

   press_counter_bank #(.CHANNELS(4), .WIDTH(8), .DEBOUNCE_CYCLES(4), .SATURATE(0), .RESET_VALUE(0)) dut_w (
      .clock(clock), .reset(reset), .countu(countu), .countd(countd), .clear(clear), .sel(sel),
      .nr_presses(nr_w), .count_all(all_w), .press_evt(press_w), .ovf_flag(ovf_w));

   press_counter_bank #(.CHANNELS(4), .WIDTH(8), .DEBOUNCE_CYCLES(4), .SATURATE(1), .RESET_VALUE(0)) dut_s (
      .clock(clock), .reset(reset), .countu(countu), .countd(countd), .clear(clear), .sel(sel),
      .nr_presses(nr_s), .count_all(all_s), .press_evt(press_s), .ovf_flag(ovf_s));

   press_counter_bank #(.CHANNELS(3), .WIDTH(4), .DEBOUNCE_CYCLES(4), .SATURATE(0), .RESET_VALUE(5)) dut_r (
      .clock(clock), .reset(reset), .countu(countu[2:0]), .countd(countd[2:0]), .clear(clear), .sel(sel),
      .nr_presses(nr_r), .count_all(all_r), .press_evt(press_r), .ovf_flag(ovf_r));

   always @(negedge clock) begin
      for (int i = 0; i < 4; i++) begin
         if (press_w[i]) evt_cnt_w[i] = evt_cnt_w[i] + 1;
         if (press_s[i]) evt_cnt_s[i] = evt_cnt_s[i] + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press_btn(input int ch, input bit up);
      if (up) countu[ch] = 1'b1; else countd[ch] = 1'b1;
      tick(10);
      if (up) countu[ch] = 1'b0; else countd[ch] = 1'b0;
      tick(10);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; countu = '0; countd = '0; clear = 1'b0; sel = 2'd0;
      tick(3);
      checks++; if (all_w !== 32'h0) begin fails++; $display("FAIL reset_count_all_w got %h expected %h", all_w, 32'h0); end
      checks++; if (nr_w !== 8'h00) begin fails++; $display("FAIL reset_nr_w got %h expected %h", nr_w, 8'h00); end
      checks++; if (press_w !== 4'h0) begin fails++; $display("FAIL reset_press_w got %h expected %h", press_w, 4'h0); end
      checks++; if (ovf_w !== 4'h0) begin fails++; $display("FAIL reset_ovf_w got %h expected %h", ovf_w, 4'h0); end
      checks++; if (all_s !== 32'h0) begin fails++; $display("FAIL reset_count_all_s got %h expected %h", all_s, 32'h0); end
      checks++; if (all_r !== 12'h555) begin fails++; $display("FAIL reset_value_all_r got %h expected %h", all_r, 12'h555); end
      checks++; if (nr_r !== 4'h5) begin fails++; $display("FAIL reset_value_nr_r got %h expected %h", nr_r, 4'h5); end
      checks++; if ({press_r, ovf_r} !== 6'h0) begin fails++; $display("FAIL reset_flags_r got %h expected %h", {press_r, ovf_r}, 6'h0); end
      reset = 1'b1;
      tick(2);
   endtask

   task automatic test_single_press();
      int base [4];
      for (int i = 0; i < 4; i++) base[i] = evt_cnt_w[i];
      countu[1] = 1'b1;
      tick(5);
      checks++; if (all_w[15:8] !== 8'd0) begin fails++; $display("FAIL single_early got %0d expected %0d", all_w[15:8], 0); end
      tick(3);
      checks++; if (all_w[15:8] !== 8'd1) begin fails++; $display("FAIL single_latency got %0d expected %0d", all_w[15:8], 1); end
      tick(12);
      countu[1] = 1'b0;
      tick(12);
      checks++; if (all_w !== 32'h0000_0100) begin fails++; $display("FAIL single_others got %h expected %h", all_w, 32'h0000_0100); end
      checks++; if (evt_cnt_w[1] - base[1] !== 1) begin fails++; $display("FAIL single_evt_count got %0d expected %0d", evt_cnt_w[1] - base[1], 1); end
      checks++; if (evt_cnt_w[0] + evt_cnt_w[2] + evt_cnt_w[3] - base[0] - base[2] - base[3] !== 0) begin
         fails++; $display("FAIL single_other_evts got %0d expected %0d", evt_cnt_w[0] + evt_cnt_w[2] + evt_cnt_w[3] - base[0] - base[2] - base[3], 0);
      end
   endtask

   task automatic test_bounce();
      int base;
      base = evt_cnt_w[0];
      for (int i = 0; i < 15; i++) begin
         countd[0] = ~countd[0];
         tick(2);
      end
      countd[0] = 1'b0;
      tick(12);
      checks++; if (evt_cnt_w[0] - base !== 0) begin fails++; $display("FAIL bounce_evts got %0d expected %0d", evt_cnt_w[0] - base, 0); end
      checks++; if (all_w[7:0] !== 8'd0) begin fails++; $display("FAIL bounce_count got %0d expected %0d", all_w[7:0], 0); end
   endtask

   task automatic test_wrap();
      press_btn(2, 1'b0);
      checks++; if (all_w[23:16] !== 8'd255) begin fails++; $display("FAIL wrap_down got %0d expected %0d", all_w[23:16], 255); end
      checks++; if (ovf_w[2] !== 1'b1) begin fails++; $display("FAIL wrap_down_flag got %b expected %b", ovf_w[2], 1'b1); end
      press_btn(2, 1'b1);
      checks++; if (all_w[23:16] !== 8'd0) begin fails++; $display("FAIL wrap_up got %0d expected %0d", all_w[23:16], 0); end
      press_btn(2, 1'b0);
      checks++; if (all_w[23:16] !== 8'd255) begin fails++; $display("FAIL wrap_down2 got %0d expected %0d", all_w[23:16], 255); end
      checks++; if (ovf_w[2] !== 1'b1) begin fails++; $display("FAIL wrap_flag_sticky got %b expected %b", ovf_w[2], 1'b1); end
      pulse_clear();
      checks++; if (all_w !== 32'h0) begin fails++; $display("FAIL wrap_clear_count got %h expected %h", all_w, 32'h0); end
      checks++; if (ovf_w !== 4'h0) begin fails++; $display("FAIL wrap_clear_flag got %h expected %h", ovf_w, 4'h0); end
   endtask

   task automatic test_reset_mid_run();
      press_btn(0, 1'b0);
      checks++; if (ovf_w[0] !== 1'b1) begin fails++; $display("FAIL midreset_pre_flag got %b expected %b", ovf_w[0], 1'b1); end
      countu[1] = 1'b1;
      tick(4);
      reset = 1'b0;
      #1;
      checks++; if (all_w !== 32'h0) begin fails++; $display("FAIL midreset_count got %h expected %h", all_w, 32'h0); end
      checks++; if (nr_w !== 8'h0) begin fails++; $display("FAIL midreset_nr got %h expected %h", nr_w, 8'h0); end
      checks++; if ({press_w, ovf_w} !== 8'h0) begin fails++; $display("FAIL midreset_flags got %h expected %h", {press_w, ovf_w}, 8'h0); end
      checks++; if (all_r !== 12'h555) begin fails++; $display("FAIL midreset_all_r got %h expected %h", all_r, 12'h555); end
      countu[1] = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(20);
      checks++; if (all_w !== 32'h0) begin fails++; $display("FAIL midreset_discard got %h expected %h", all_w, 32'h0); end
   endtask

   task automatic test_saturate();
      int base;
      base = evt_cnt_s[3];
      press_btn(3, 1'b0);
      checks++; if (all_s[31:24] !== 8'd0) begin fails++; $display("FAIL sat_low got %0d expected %0d", all_s[31:24], 0); end
      checks++; if (evt_cnt_s[3] - base !== 1) begin fails++; $display("FAIL sat_low_evt got %0d expected %0d", evt_cnt_s[3] - base, 1); end
      checks++; if (ovf_s[3] !== 1'b1) begin fails++; $display("FAIL sat_low_flag got %b expected %b", ovf_s[3], 1'b1); end
      pulse_clear();
      for (int i = 0; i < 255; i++) press_btn(3, 1'b1);
      checks++; if (all_s[31:24] !== 8'd255) begin fails++; $display("FAIL sat_climb got %0d expected %0d", all_s[31:24], 255); end
      checks++; if (all_w[31:24] !== 8'd255) begin fails++; $display("FAIL wrap_climb got %0d expected %0d", all_w[31:24], 255); end
      checks++; if (ovf_w[3] !== 1'b0) begin fails++; $display("FAIL wrap_no_early_flag got %b expected %b", ovf_w[3], 1'b0); end
      base = evt_cnt_s[3];
      press_btn(3, 1'b1);
      checks++; if (all_s[31:24] !== 8'd255) begin fails++; $display("FAIL sat_high got %0d expected %0d", all_s[31:24], 255); end
      checks++; if (ovf_s[3] !== 1'b1) begin fails++; $display("FAIL sat_high_flag got %b expected %b", ovf_s[3], 1'b1); end
      checks++; if (evt_cnt_s[3] - base !== 1) begin fails++; $display("FAIL sat_high_evt got %0d expected %0d", evt_cnt_s[3] - base, 1); end
      checks++; if (all_w[31:24] !== 8'd0) begin fails++; $display("FAIL wrap_up_top got %0d expected %0d", all_w[31:24], 0); end
      checks++; if (ovf_w[3] !== 1'b1) begin fails++; $display("FAIL wrap_up_flag got %b expected %b", ovf_w[3], 1'b1); end
   endtask

   task automatic test_simultaneous();
      int base;
      base = evt_cnt_w[0];
      countu[0] = 1'b1;
      countd[0] = 1'b1;
      tick(10);
      countu[0] = 1'b0;
      countd[0] = 1'b0;
      tick(10);
      checks++; if (all_w[7:0] !== 8'd0) begin fails++; $display("FAIL simul_count got %0d expected %0d", all_w[7:0], 0); end
      checks++; if (evt_cnt_w[0] - base !== 0) begin fails++; $display("FAIL simul_evt got %0d expected %0d", evt_cnt_w[0] - base, 0); end
   endtask

   task automatic test_clear_vs_press();
      int base;
      press_btn(1, 1'b1);
      checks++; if (all_w[15:8] !== 8'd1) begin fails++; $display("FAIL clrpress_pre got %0d expected %0d", all_w[15:8], 1); end
      base = evt_cnt_w[1];
      countu[1] = 1'b1;
      tick(5);
      clear = 1'b1;
      tick(3);
      clear = 1'b0;
      checks++; if (all_w[15:8] !== 8'd0) begin fails++; $display("FAIL clrpress_count got %0d expected %0d", all_w[15:8], 0); end
      tick(5);
      countu[1] = 1'b0;
      tick(10);
      checks++; if (all_w[15:8] !== 8'd0) begin fails++; $display("FAIL clrpress_after got %0d expected %0d", all_w[15:8], 0); end
      checks++; if (evt_cnt_w[1] - base !== 0) begin fails++; $display("FAIL clrpress_evt got %0d expected %0d", evt_cnt_w[1] - base, 0); end
   endtask

   task automatic test_sel();
      for (int i = 0; i < 5; i++) press_btn(2, 1'b1);
      sel = 2'd2;
      #1;
      checks++; if (nr_w !== 8'd0) begin fails++; $display("FAIL sel_registered got %0d expected %0d", nr_w, 0); end
      tick(1);
      checks++; if (nr_w !== 8'd5) begin fails++; $display("FAIL sel_ch2 got %0d expected %0d", nr_w, 5); end
      sel = 2'd3;
      tick(1);
      checks++; if (nr_r !== 4'd0) begin fails++; $display("FAIL sel_out_of_range got %0d expected %0d", nr_r, 0); end
      checks++; if (nr_w !== 8'd0) begin fails++; $display("FAIL sel_ch3 got %0d expected %0d", nr_w, 0); end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_wrap();
      test_reset_mid_run();
      test_saturate();
      test_simultaneous();
      test_clear_vs_press();
      test_sel();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
